// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker with lock/loss-of-lock tracking
//
// Seeds a local LFSR from the incoming bit stream, verifies the seeded copy
// against further received bits, then free-runs (flywheel) once locked and
// counts every received bit that disagrees with the local prediction.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din_valid  qualifies din; nothing advances while low
//   din        received serial bit
//   clr_cnt    synchronous clear of err_cnt
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatch seen in LOCKED
//   err_cnt    saturating count of LOCKED mismatches
//   state      current state: SEED=0, VERIFY=1, LOCKED=2

module prbs_checker #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
    parameter int               LOCK_COUNT  = 16,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [1:0]  state
);

    localparam int SCW = $clog2(WIDTH + 1);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int WCW = $clog2(WINDOW + 1);

    localparam logic [SCW-1:0] SEED_LAST  = SCW'(WIDTH - 1);
    localparam logic [MCW-1:0] MATCH_LAST = MCW'(LOCK_COUNT - 1);
    localparam logic [WCW-1:0] WIN_LAST   = WCW'(WINDOW - 1);
    localparam logic [WCW-1:0] ERR_THRESH = WCW'(LOSS_THRESH);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           cur;
    logic [WIDTH-1:0] sr;
    logic [SCW-1:0]   seed_cnt;
    logic [MCW-1:0]   match_cnt;
    logic [WCW-1:0]   win_bits;
    logic [WCW-1:0]   win_errs;

    logic             pred;
    logic             mismatch;
    logic             lock_err;
    logic [WIDTH-1:0] sr_seeded;
    logic [WIDTH-1:0] sr_fly;
    logic [WCW-1:0]   win_errs_inc;

    assign state = cur;

    always_comb begin
        pred         = ^(sr & TAPS);
        mismatch     = din ^ pred;
        sr_seeded    = {sr[WIDTH-2:0], din};
        // once locked the register runs on its own prediction, so a corrupted
        // received bit never poisons the following predictions
        sr_fly       = {sr[WIDTH-2:0], pred};
        lock_err     = din_valid && (cur == ST_LOCKED) && mismatch;
        win_errs_inc = win_errs + WCW'(lock_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= ST_SEED;
            sr        <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= lock_err;

            // the error counter is independent of state transitions; a clear
            // coinciding with an error keeps that error
            if (clr_cnt) begin
                err_cnt <= {15'd0, lock_err};
            end else if (lock_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (din_valid) begin
                case (cur)
                    ST_SEED: begin
                        sr <= sr_seeded;
                        if (seed_cnt == SEED_LAST) begin
                            seed_cnt <= '0;
                            // an all-zero register is the LFSR lock-up state
                            if (sr_seeded != '0) begin
                                cur       <= ST_VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + 1'b1;
                        end
                    end

                    ST_VERIFY: begin
                        sr <= sr_seeded;
                        if (mismatch) begin
                            cur       <= ST_SEED;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                            win_bits  <= '0;
                            win_errs  <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            cur       <= ST_LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                            win_bits  <= '0;
                            win_errs  <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end

                    ST_LOCKED: begin
                        sr <= sr_fly;
                        if (win_bits == WIN_LAST) begin
                            // window closes; the closing bit's own error counts
                            win_bits <= '0;
                            win_errs <= '0;
                            if (win_errs_inc >= ERR_THRESH) begin
                                cur       <= ST_SEED;
                                locked    <= 1'b0;
                                seed_cnt  <= '0;
                                match_cnt <= '0;
                            end
                        end else begin
                            win_bits <= win_bits + 1'b1;
                            win_errs <= win_errs_inc;
                        end
                    end

                    default: begin
                        cur       <= ST_SEED;
                        locked    <= 1'b0;
                        seed_cnt  <= '0;
                        match_cnt <= '0;
                        win_bits  <= '0;
                        win_errs  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
